// File: rtl/layer1_sequencer_if.sv
// Bundle between the layer-1 sequencer and its memories, neuron and result consumer.
// Result stream: a beat transfers on a cycle where res_valid and res_ready are both high;
// once raised, res_valid, res_data and res_index hold until that transfer.
interface layer1_sequencer_if #(
  parameter int PIX_AW = 10,
  parameter int W_AW   = 15,
  parameter int NRN_W  = 5
);
  logic              start;
  logic              busy;
  logic              done;
  logic [PIX_AW-1:0] pix_addr;
  logic [31:0]       pix_data;
  logic [W_AW-1:0]   w_addr;
  logic [31:0]       w_data;
  logic [NRN_W-1:0]  b_addr;
  logic [31:0]       b_data;
  logic              n_bias_load;
  logic              n_valid;
  logic [31:0]       n_value;
  logic [31:0]       n_weight;
  logic [31:0]       n_relu;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic [NRN_W-1:0]  res_index;

  modport master (
    input  start, pix_data, w_data, b_data, n_relu, res_ready,
    output busy, done, pix_addr, w_addr, b_addr, n_bias_load, n_valid,
           n_value, n_weight, res_valid, res_data, res_index
  );

  modport slave (
    output start, pix_data, w_data, b_data, n_relu, res_ready,
    input  busy, done, pix_addr, w_addr, b_addr, n_bias_load, n_valid,
           n_value, n_weight, res_valid, res_data, res_index
  );
endinterface

// File: rtl/layer1_sequencer.sv
// Walks every hidden neuron of one image: bias load, N_INPUTS MAC beats, pipeline drain,
// then presents the ReLU result on the valid/ready stream.
module layer1_sequencer #(
  parameter int N_INPUTS  = 784,
  parameter int N_NEURONS = 32,
  parameter int PIX_AW    = 10,
  parameter int W_AW      = 15,
  parameter int NRN_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  layer1_sequencer_if.master   bus,
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS_RD, S_BIAS_LD, S_MAC, S_LAST, S_DRAIN, S_CAPTURE, S_OUT
  } state_t;

  localparam logic [PIX_AW-1:0] LAST_I = PIX_AW'(N_INPUTS - 1);
  localparam logic [NRN_W-1:0]  LAST_K = NRN_W'(N_NEURONS - 1);

  state_t            r_state;
  logic [NRN_W-1:0]  r_k;
  logic [PIX_AW-1:0] r_pix_addr;
  logic [W_AW-1:0]   r_w_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_bias_load;
  logic              r_n_valid;
  logic              r_res_valid;
  logic [31:0]       r_res_data;
  logic [NRN_W-1:0]  r_res_index;
  logic              w_handshake;

  assign w_handshake = (r_state == S_OUT) && r_res_valid && bus.res_ready;

  // The address registers double as the input index i and the running weight pointer wp,
  // so wp simply keeps counting across neurons without any multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_pix_addr  <= '0;
      r_w_addr    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bias_load <= 1'b0;
      r_n_valid   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_index <= '0;
    end else begin
      r_done      <= 1'b0;
      r_bias_load <= 1'b0;
      r_n_valid   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_k        <= '0;
            r_pix_addr <= '0;
            r_w_addr   <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_BIAS_RD;
          end
        end
        S_BIAS_RD: begin
          r_bias_load <= 1'b1;
          r_state     <= S_BIAS_LD;
        end
        S_BIAS_LD: r_state <= S_MAC;
        S_MAC: begin
          r_n_valid <= 1'b1;
          r_w_addr  <= r_w_addr + 1'b1;
          if (r_pix_addr == LAST_I) begin
            r_pix_addr <= '0;
            r_state    <= S_LAST;
          end else begin
            r_pix_addr <= r_pix_addr + 1'b1;
          end
        end
        S_LAST:  r_state <= S_DRAIN;
        // No bias load here: the neuron is still accumulating the final product.
        S_DRAIN: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_res_data  <= bus.n_relu;
          r_res_index <= r_k;
          r_res_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (w_handshake) begin
            r_res_valid <= 1'b0;
            if (r_k == LAST_K) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_k     <= r_k + 1'b1;
              r_state <= S_BIAS_RD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pix_addr    = r_pix_addr;
  assign bus.w_addr      = r_w_addr;
  assign bus.b_addr      = r_k;
  assign bus.n_bias_load = r_bias_load;
  assign bus.n_valid     = r_n_valid;
  assign bus.n_value     = r_bias_load ? bus.b_data : bus.pix_data;
  assign bus.n_weight    = bus.w_data;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_data    = r_res_data;
  assign bus.res_index   = r_res_index;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_layer1_sequencer.sv
// Bench for layer1_sequencer: sync-read memories and a two-stage neuron around the DUT,
// results scored against a plain-arithmetic model of one image.
module tb_layer1_sequencer;
  localparam int N_INPUTS  = 4;
  localparam int N_NEURONS = 2;
  localparam int PIX_AW    = 10;
  localparam int W_AW      = 15;
  localparam int NRN_W     = 5;
  localparam int N_W       = N_INPUTS * N_NEURONS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  layer1_sequencer_if #(.PIX_AW(PIX_AW), .W_AW(W_AW), .NRN_W(NRN_W)) bus ();

  layer1_sequencer #(
    .N_INPUTS(N_INPUTS), .N_NEURONS(N_NEURONS),
    .PIX_AW(PIX_AW), .W_AW(W_AW), .NRN_W(NRN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memories with one-cycle read latency
  logic [31:0] pix_mem [N_INPUTS];
  logic [31:0] w_mem   [N_W];
  logic [31:0] b_mem   [N_NEURONS];

  always @(posedge clk) begin
    bus.pix_data <= pix_mem[int'(bus.pix_addr) % N_INPUTS];
    bus.w_data   <= w_mem[int'(bus.w_addr) % N_W];
    bus.b_data   <= b_mem[int'(bus.b_addr) % N_NEURONS];
  end

  // neuron: stage 1 registers the product, stage 2 accumulates; accumulate wins over bias load
  logic [63:0] nr_prod;
  logic        nr_pv;
  logic [31:0] nr_acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      nr_prod <= '0;
      nr_pv   <= 1'b0;
      nr_acc  <= '0;
    end else begin
      nr_pv <= bus.n_valid;
      if (bus.n_valid)
        nr_prod <= $signed({{32{bus.n_value[31]}}, bus.n_value}) *
                   $signed({{32{bus.n_weight[31]}}, bus.n_weight});
      if (nr_pv)
        nr_acc <= nr_acc + nr_prod[47:16];
      else if (bus.n_bias_load)
        nr_acc <= bus.n_value;
    end
  end

  assign bus.n_relu = nr_acc[31] ? 32'd0 : nr_acc;

  // res_ready driver
  logic bp_mode   = 1'b0;
  logic rdy_force = 1'b1;

  initial begin
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.res_ready = bp_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // monitor: records handshakes and the address behind every bias/MAC beat
  logic [63:0]       obs_q [$];
  logic [W_AW-1:0]   wseq  [$];
  logic [PIX_AW-1:0] pseq  [$];
  logic [NRN_W-1:0]  bseq  [$];
  int                done_cnt = 0;
  int                excl_err = 0;
  int                done_busy_err = 0;
  logic [W_AW-1:0]   prev_w;
  logic [PIX_AW-1:0] prev_p;
  logic [NRN_W-1:0]  prev_b;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.res_valid && bus.res_ready)
        obs_q.push_back(64'({bus.res_index, bus.res_data}));
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        if (bus.busy) done_busy_err <= done_busy_err + 1;
      end
      if (bus.n_valid && bus.n_bias_load) excl_err <= excl_err + 1;
      if (bus.n_valid) begin
        wseq.push_back(prev_w);
        pseq.push_back(prev_p);
      end
      if (bus.n_bias_load) bseq.push_back(prev_b);
    end
    prev_w <= bus.w_addr;
    prev_p <= bus.pix_addr;
    prev_b <= bus.b_addr;
  end

  // scoreboard
  logic [63:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // reference: relu(bias + sum of product bits [47:16]) with 32-bit wrap
  function automatic logic [31:0] ref_neuron(input int k);
    logic [31:0] acc;
    longint      p;
    acc = b_mem[k];
    for (int i = 0; i < N_INPUTS; i++) begin
      p   = longint'($signed(pix_mem[i])) * longint'($signed(w_mem[k*N_INPUTS + i]));
      acc = acc + 32'(p >>> 16);
    end
    return ($signed(acc) < 0) ? 32'd0 : acc;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rnd_q(input int unsigned mag);
    logic [31:0] v;
    v = $urandom_range(0, mag);
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  task automatic fill_directed;
    b_mem[0] = 32'h0001_0000;
    b_mem[1] = 32'hFFF8_0000;
    for (int i = 0; i < N_INPUTS; i++) pix_mem[i] = 32'h0001_0000;
    for (int j = 0; j < N_W; j++) w_mem[j] = 32'h0000_8000;
    exp_q.delete();
    exp_q.push_back(64'({NRN_W'(0), 32'h0003_0000}));
    exp_q.push_back(64'({NRN_W'(1), 32'h0000_0000}));
  endtask

  task automatic fill_random;
    for (int k = 0; k < N_NEURONS; k++) b_mem[k] = rnd_q(32'h0008_0000);
    for (int i = 0; i < N_INPUTS; i++) pix_mem[i] = rnd_q(32'h0004_0000);
    for (int j = 0; j < N_W; j++)
      w_mem[j] = ($urandom_range(0, 7) == 0) ? $urandom() : rnd_q(32'h0003_0000);
    exp_q.delete();
    for (int k = 0; k < N_NEURONS; k++) exp_q.push_back(64'({NRN_W'(k), ref_neuron(k)}));
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_busy"},      64'(bus.busy),        64'd0);
    check_eq({pfx, "_done"},      64'(bus.done),        64'd0);
    check_eq({pfx, "_bias_load"}, 64'(bus.n_bias_load), 64'd0);
    check_eq({pfx, "_n_valid"},   64'(bus.n_valid),     64'd0);
    check_eq({pfx, "_res_valid"}, 64'(bus.res_valid),   64'd0);
    check_eq({pfx, "_res_data"},  64'(bus.res_data),    64'd0);
    check_eq({pfx, "_res_index"}, 64'(bus.res_index),   64'd0);
    check_eq({pfx, "_pix_addr"},  64'(bus.pix_addr),    64'd0);
    check_eq({pfx, "_w_addr"},    64'(bus.w_addr),      64'd0);
    check_eq({pfx, "_b_addr"},    64'(bus.b_addr),      64'd0);
    check_eq({pfx, "_state"},     64'(dbg_state),       64'd0);
  endtask

  task automatic run_image(input bit directed, input bit stall, input bit extra_start);
    int ob, wb, pb, bb, db, c, n_obs, n_w, n_p, n_b;
    ob = obs_q.size(); wb = wseq.size(); pb = pseq.size(); bb = bseq.size(); db = done_cnt;
    if (stall) rdy_force = 1'b0;
    tick;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    c = 1;
    while (!bus.res_valid && c < 100) begin
      bus.start = (extra_start && c == 5);
      tick;
      c++;
    end
    bus.start = 1'b0;
    check_eq("res_valid_timeout", 64'(c < 100), 64'd1);
    if (directed && !stall && !bp_mode)
      check_eq("first_res_valid_cycle", 64'(c), 64'(N_INPUTS + 6));
    if (stall) begin
      for (int s = 0; s < 5; s++) begin
        check_eq("stall_res_valid", 64'(bus.res_valid), 64'd1);
        check_eq("stall_res_data",  64'(bus.res_data),  64'(exp_q[0][31:0]));
        check_eq("stall_res_index", 64'(bus.res_index), 64'd0);
        check_eq("stall_pix_addr",  64'(bus.pix_addr),  64'd0);
        check_eq("stall_w_addr",    64'(bus.w_addr),    64'(N_INPUTS));
        check_eq("stall_b_addr",    64'(bus.b_addr),    64'd0);
        tick;
      end
      rdy_force = 1'b1;
    end
    c = 0;
    while (done_cnt == db && c < 2000) begin
      tick;
      c++;
    end
    check_eq("done_timeout", 64'(done_cnt != db), 64'd1);
    repeat (4) tick;
    check_eq("done_pulses", 64'(done_cnt - db), 64'd1);
    check_eq("busy_after_done", 64'(bus.busy), 64'd0);
    n_obs = obs_q.size() - ob;
    check_eq("result_count", 64'(n_obs), 64'(N_NEURONS));
    for (int k = 0; k < N_NEURONS && k < n_obs; k++)
      check_eq($sformatf("result_%0d", k), obs_q[ob + k], exp_q[k]);
    n_w = wseq.size() - wb;
    n_p = pseq.size() - pb;
    n_b = bseq.size() - bb;
    check_eq("w_beats", 64'(n_w), 64'(N_W));
    check_eq("p_beats", 64'(n_p), 64'(N_W));
    check_eq("b_beats", 64'(n_b), 64'(N_NEURONS));
    for (int j = 0; j < N_W && j < n_w; j++)
      check_eq($sformatf("w_addr_%0d", j), 64'(wseq[wb + j]), 64'(j));
    for (int j = 0; j < N_W && j < n_p; j++)
      check_eq($sformatf("pix_addr_%0d", j), 64'(pseq[pb + j]), 64'(j % N_INPUTS));
    for (int k = 0; k < N_NEURONS && k < n_b; k++)
      check_eq($sformatf("b_addr_%0d", k), 64'(bseq[bb + k]), 64'(k));
  endtask

  task automatic run_abort;
    int ob, db, c;
    fill_random;
    ob = obs_q.size(); db = done_cnt;
    tick;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    c = 0;
    while (!(bus.n_valid && bus.b_addr == NRN_W'(1)) && c < 200) begin
      tick;
      c++;
    end
    check_eq("abort_reach_mac1", 64'(c < 200), 64'd1);
    tick;
    #1 rst = 1'b1;
    #1 check_reset_vals("abort");
    tick;
    tick;
    rst = 1'b0;
    repeat (3) tick;
    check_eq("abort_no_done", 64'(done_cnt - db), 64'd0);
    check_eq("abort_results", 64'(obs_q.size() - ob), 64'd1);
    if (obs_q.size() > ob) check_eq("abort_result_0", obs_q[ob], exp_q[0]);
  endtask

  // main sequence
  initial begin
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset");
    rst = 1'b0;
    tick;

    fill_directed;
    run_image(1'b1, 1'b0, 1'b0);
    fill_directed;
    run_image(1'b1, 1'b1, 1'b0);
    run_abort;
    fill_random;
    run_image(1'b0, 1'b0, 1'b0);
    fill_random;
    run_image(1'b0, 1'b0, 1'b1);
    bp_mode = 1'b1;
    for (int n = 0; n < 4; n++) begin
      fill_random;
      run_image(1'b0, 1'b0, 1'b0);
    end
    bp_mode = 1'b0;
    tick;

    check_eq("valid_and_bias_load", 64'(excl_err), 64'd0);
    check_eq("done_while_busy", 64'(done_busy_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
